reg_file_sb: RTL and testbench

Sixteen-entry, 16-bit register file with a pending-write scoreboard, sitting directly upstream of the per-register storage cells in the decode stage. It converts 4-bit register IDs into one-hot read/write wordlines and drives two read ports with optional write-to-read bypass. It tracks which registers have an issued-but-not-written-back producer and raises a stall to the issue logic when a requested source is not yet valid.

---
 rtl/reg_file_sb_pkg.sv | 14 +
 rtl/reg_file_sb_if.sv | 35 +++
 rtl/reg_file_sb_reg_id_decoder.sv | 19 +
 rtl/reg_file_sb.sv | 96 +++++++++
 tb/tb_reg_file_sb.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/reg_file_sb_pkg.sv
// Shared types and sizing for the register file / scoreboard slice.
// The bypass build option is selected by REGFILE_BYPASS_EN (see reg_file_sb.sv).
package reg_file_pkg;

   localparam int REG_ID_W = 4;
   localparam int WIDTH    = 16;
   localparam int NUM_REGS = 16;

   typedef logic [REG_ID_W-1:0] reg_id_t;
   typedef logic [WIDTH-1:0]    data_t;

   localparam reg_id_t ZERO_REG = '0;

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode-stage bus between the issue/writeback logic (master) and the
// register file with scoreboard (slave).
interface reg_file_sb_if;
   import reg_file_pkg::*;

   reg_id_t                SrcReg1;
   reg_id_t                SrcReg2;
   logic                   ReadEnable1;
   logic                   ReadEnable2;
   data_t                  SrcData1;
   data_t                  SrcData2;
   logic                   WriteReg;
   reg_id_t                DstReg;
   data_t                  DstData;
   logic                   IssueValid;
   reg_id_t                IssueDst;
   logic                   IssueWrites;
   logic                   Stall;
   logic [NUM_REGS-1:0]    BusyMask;

   modport master (
      output SrcReg1, SrcReg2, ReadEnable1, ReadEnable2,
      output WriteReg, DstReg, DstData,
      output IssueValid, IssueDst, IssueWrites,
      input  SrcData1, SrcData2, Stall, BusyMask
   );

   modport slave (
      input  SrcReg1, SrcReg2, ReadEnable1, ReadEnable2,
      input  WriteReg, DstReg, DstData,
      input  IssueValid, IssueDst, IssueWrites,
      output SrcData1, SrcData2, Stall, BusyMask
   );

endinterface

// File: rtl/reg_file_sb_reg_id_decoder.sv
// Register ID to one-hot wordline decoder with enable; FORCE_R0_LOW keeps
// the R0 wordline permanently inactive.
module reg_id_decoder
   import reg_file_pkg::*;
#(
   parameter bit FORCE_R0_LOW = 1'b0
) (
   input  reg_id_t             id,
   input  logic                en,
   output logic [NUM_REGS-1:0] onehot
);

   always_comb begin
      onehot = '0;
      if (en) onehot[id] = 1'b1;
      if (FORCE_R0_LOW) onehot[0] = 1'b0;
   end

endmodule

// File: rtl/reg_file_sb.sv
// Sixteen-entry register file with pending-write scoreboard and stall.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module reg_file_sb
   import reg_file_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   reg_file_sb_if.slave  bus
);

   data_t               regs [NUM_REGS];
   logic [NUM_REGS-1:0] busy;
   logic [NUM_REGS-1:0] wr_wl;
   logic [NUM_REGS-1:0] rd_wl1;
   logic [NUM_REGS-1:0] rd_wl2;
   logic [NUM_REGS-1:0] issue_set;
   data_t               stored1;
   data_t               stored2;
   logic                hit1;
   logic                hit2;
   logic                stall1;
   logic                stall2;

   reg_id_decoder #(.FORCE_R0_LOW(1'b1)) u_dec_wr (
      .id     (bus.DstReg),
      .en     (bus.WriteReg),
      .onehot (wr_wl)
   );

   reg_id_decoder #(.FORCE_R0_LOW(1'b0)) u_dec_rd1 (
      .id     (bus.SrcReg1),
      .en     (bus.ReadEnable1),
      .onehot (rd_wl1)
   );

   reg_id_decoder #(.FORCE_R0_LOW(1'b0)) u_dec_rd2 (
      .id     (bus.SrcReg2),
      .en     (bus.ReadEnable2),
      .onehot (rd_wl2)
   );

   // R0 is never selected by wr_wl, so it holds its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_wl[i]) regs[i] <= bus.DstData;
         end
      end
   end

   always_comb begin
      issue_set = '0;
      if (bus.IssueValid && bus.IssueWrites && (bus.IssueDst != ZERO_REG))
         issue_set[bus.IssueDst] = 1'b1;
   end

   // Set is applied after clear so a new producer wins a same-ID collision.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) busy <= '0;
      else     busy <= (busy & ~wr_wl) | issue_set;
   end

   always_comb begin
      stored1 = '0;
      stored2 = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (rd_wl1[i]) stored1 = stored1 | regs[i];
         if (rd_wl2[i]) stored2 = stored2 | regs[i];
      end
   end

`ifdef REGFILE_BYPASS_EN
   // Forwarding is suppressed during reset, when no writeback is honoured.
   always_comb begin
      hit1 = !rst && bus.WriteReg && (bus.DstReg != ZERO_REG) && (bus.DstReg == bus.SrcReg1);
      hit2 = !rst && bus.WriteReg && (bus.DstReg != ZERO_REG) && (bus.DstReg == bus.SrcReg2);
   end
`else
   always_comb begin
      hit1 = 1'b0;
      hit2 = 1'b0;
   end
`endif

   always_comb begin
      bus.SrcData1 = (bus.ReadEnable1 && hit1) ? bus.DstData : stored1;
      bus.SrcData2 = (bus.ReadEnable2 && hit2) ? bus.DstData : stored2;
      stall1 = bus.ReadEnable1 && (bus.SrcReg1 != ZERO_REG) && busy[bus.SrcReg1] && !hit1;
      stall2 = bus.ReadEnable2 && (bus.SrcReg2 != ZERO_REG) && busy[bus.SrcReg2] && !hit2;
      bus.Stall    = stall1 || stall2;
      bus.BusyMask = busy;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb; expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_sb;
   import reg_file_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   reg_file_sb_if bus ();

   reg_file_sb dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
      end
   endtask

   task automatic idle();
      bus.SrcReg1 = '0;  bus.SrcReg2 = '0;
      bus.ReadEnable1 = 1'b0; bus.ReadEnable2 = 1'b0;
      bus.WriteReg = 1'b0; bus.DstReg = '0; bus.DstData = '0;
      bus.IssueValid = 1'b0; bus.IssueDst = '0; bus.IssueWrites = 1'b0;
   endtask

   initial begin
      // Reset with random inputs
      idle();
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         bus.SrcReg1 = 4'($urandom); bus.SrcReg2 = 4'($urandom);
         bus.ReadEnable1 = 1'($urandom); bus.ReadEnable2 = 1'($urandom);
         bus.WriteReg = 1'b1; bus.DstReg = bus.SrcReg1; bus.DstData = 16'($urandom);
         bus.IssueValid = 1'($urandom); bus.IssueDst = 4'($urandom); bus.IssueWrites = 1'($urandom);
         tick();
      end
      check("rst_src1", bus.SrcData1, 16'h0000);
      check("rst_src2", bus.SrcData2, 16'h0000);
      check("rst_busy", bus.BusyMask, 16'h0000);
      check("rst_stall", {15'd0, bus.Stall}, 16'h0000);
      idle();
      rst = 1'b0;
      tick();
      bus.SrcReg1 = 4'd5; bus.ReadEnable1 = 1'b1;
      #1 check("post_rst_r5", bus.SrcData1, 16'h0000);

      // Write / read, R0 drop, disabled port
      idle();
      bus.WriteReg = 1'b1; bus.DstReg = 4'd3; bus.DstData = 16'hFFFF;
      tick();
      idle();
      bus.SrcReg1 = 4'd3; bus.SrcReg2 = 4'd3; bus.ReadEnable1 = 1'b1; bus.ReadEnable2 = 1'b1;
      #1 check("rd_r3_p1", bus.SrcData1, 16'hFFFF);
      check("rd_r3_p2", bus.SrcData2, 16'hFFFF);
      check("wr_nonbusy_busy", bus.BusyMask, 16'h0000);
      bus.ReadEnable2 = 1'b0;
      #1 check("rd_disabled_p2", bus.SrcData2, 16'h0000);
      idle();
      bus.WriteReg = 1'b1; bus.DstReg = 4'd0; bus.DstData = 16'h1234;
      tick();
      idle();
      bus.SrcReg1 = 4'd0; bus.ReadEnable1 = 1'b1;
      #1 check("rd_r0", bus.SrcData1, 16'h0000);

      // Issue to R0 never sets busy
      idle();
      bus.IssueValid = 1'b1; bus.IssueWrites = 1'b1; bus.IssueDst = 4'd0;
      tick();
      idle();
      check("issue_r0_busy", bus.BusyMask, 16'h0000);

      // Scoreboard: issue R7, dependent read stalls, writeback clears
      bus.IssueValid = 1'b1; bus.IssueWrites = 1'b1; bus.IssueDst = 4'd7;
      tick();
      idle();
      bus.SrcReg1 = 4'd7; bus.ReadEnable1 = 1'b1;
      #1 check("sb_stall", {15'd0, bus.Stall}, 16'h0001);
      check("sb_busy", bus.BusyMask, 16'h0080);
      bus.ReadEnable1 = 1'b0;
      bus.SrcReg2 = 4'd7; bus.ReadEnable2 = 1'b1;
      #1 check("sb_stall_p2", {15'd0, bus.Stall}, 16'h0001);
      bus.ReadEnable2 = 1'b0;
      #1 check("sb_stall_disabled", {15'd0, bus.Stall}, 16'h0000);
      bus.ReadEnable1 = 1'b1;
      bus.WriteReg = 1'b1; bus.DstReg = 4'd7; bus.DstData = 16'hBEEF;
      tick();
      bus.WriteReg = 1'b0;
      #1 check("wb_stall", {15'd0, bus.Stall}, 16'h0000);
      check("wb_data", bus.SrcData1, 16'hBEEF);
      check("wb_busy", bus.BusyMask, 16'h0000);

      // Bypass / writeback-cycle behaviour
      idle();
      bus.IssueValid = 1'b1; bus.IssueWrites = 1'b1; bus.IssueDst = 4'd7;
      tick();
      idle();
      bus.SrcReg1 = 4'd7; bus.ReadEnable1 = 1'b1;
      bus.WriteReg = 1'b1; bus.DstReg = 4'd7; bus.DstData = 16'hA5A5;
      #1;
`ifdef REGFILE_BYPASS_EN
      check("byp_data", bus.SrcData1, 16'hA5A5);
      check("byp_stall", {15'd0, bus.Stall}, 16'h0000);
`else
      check("nobyp_data", bus.SrcData1, 16'hBEEF);
      check("nobyp_stall", {15'd0, bus.Stall}, 16'h0001);
`endif
      tick();
      bus.WriteReg = 1'b0;
      #1 check("byp_next_data", bus.SrcData1, 16'hA5A5);
      check("byp_next_stall", {15'd0, bus.Stall}, 16'h0000);

      // Collision: set wins, data still written
      idle();
      bus.IssueValid = 1'b1; bus.IssueWrites = 1'b1; bus.IssueDst = 4'd4;
      bus.WriteReg = 1'b1; bus.DstReg = 4'd4; bus.DstData = 16'h4444;
      tick();
      idle();
      check("coll_busy", bus.BusyMask, 16'h0010);
      bus.SrcReg1 = 4'd4; bus.ReadEnable1 = 1'b1;
      #1 check("coll_data", bus.SrcData1, 16'h4444);
      check("coll_stall", {15'd0, bus.Stall}, 16'h0001);

      // Reset mid-flight
      idle();
      bus.WriteReg = 1'b1; bus.DstReg = 4'd2; bus.DstData = 16'h2222;
      tick();
      idle();
      bus.IssueValid = 1'b1; bus.IssueWrites = 1'b1; bus.IssueDst = 4'd2;
      tick();
      idle();
      check("mid_busy_pre", bus.BusyMask, 16'h0014);
      bus.SrcReg1 = 4'd2; bus.ReadEnable1 = 1'b1;
      bus.WriteReg = 1'b1; bus.DstReg = 4'd2; bus.DstData = 16'h9999;
      rst = 1'b1;
      #1 check("mid_rst_busy", bus.BusyMask, 16'h0000);
      check("mid_rst_data", bus.SrcData1, 16'h0000);
      check("mid_rst_stall", {15'd0, bus.Stall}, 16'h0000);
      tick();
      bus.WriteReg = 1'b0;
      rst = 1'b0;
      tick();
      check("mid_after_r2", bus.SrcData1, 16'h0000);
      check("mid_after_busy", bus.BusyMask, 16'h0000);
      bus.SrcReg1 = 4'd3;
      #1 check("mid_after_r3", bus.SrcData1, 16'h0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
